// File: rtl/mips_data_mem_arbiter.sv
// Two-port request/ack arbiter in front of the single-port MIPS data memory.
// Each access takes three enabled cycles: IDLE (grant) -> ISSUE (strobe) -> RESP (capture), ack follows.
module mips_data_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,

  input  logic              req0_read,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_address,
  input  logic [DATA_W-1:0] req0_writedata,
  output logic              ack0,
  output logic [DATA_W-1:0] rd0_data,

  input  logic              req1_read,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_address,
  input  logic [DATA_W-1:0] req1_writedata,
  output logic              ack1,
  output logic [DATA_W-1:0] rd1_data,

  output logic              mem_clk_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,

  output logic [1:0]        o_dbg_state
);

  // Handshake: a port raises reqN_read/reqN_write and holds address/data until ackN
  // pulses for one enabled cycle; values are latched at grant, and a port whose ack
  // is high is masked for that cycle so a still-held request is not served twice.

  // o_dbg_state encoding: 0 = IDLE, 1 = ISSUE, 2 = RESP.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_rr_last;
  logic              r_win;
  logic              r_op_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_ack0;
  logic              r_ack1;
  logic [DATA_W-1:0] r_rd0;
  logic [DATA_W-1:0] r_rd1;

  logic              w_elig0;
  logic              w_elig1;
  logic              w_any;
  logic              w_win;
  logic              w_grant;
  logic              w_done;

  always_comb begin
    w_elig0 = (req0_read | req0_write) & ~r_ack0;
    w_elig1 = (req1_read | req1_write) & ~r_ack1;
    w_any   = w_elig0 | w_elig1;
    if (w_elig0 & w_elig1) begin
      w_win = (FIXED_PRIO != 0) ? 1'b0 : ~r_rr_last;
    end else begin
      w_win = w_elig1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Read+write together was decoded as a write at grant.
        mem_write   = r_op_wr;
        mem_read    = ~r_op_wr;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
    end else if (clk_enable) begin
      r_state <= w_state_nxt;
      r_ack0  <= w_done & ~r_win;
      r_ack1  <= w_done & r_win;
    end
  end

  // rr_last starts at 1 so port 0 wins the first tie; it tracks the last port served.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_last <= 1'b1;
      r_win     <= 1'b0;
      r_op_wr   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else if (clk_enable && w_grant) begin
      r_rr_last <= w_win;
      r_win     <= w_win;
      r_op_wr   <= w_win ? req1_write     : req0_write;
      r_addr    <= w_win ? req1_address   : req0_address;
      r_wdata   <= w_win ? req1_writedata : req0_writedata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd0 <= '0;
      r_rd1 <= '0;
    end else if (clk_enable && w_done && !r_op_wr) begin
      if (r_win) begin
        r_rd1 <= mem_readdata;
      end else begin
        r_rd0 <= mem_readdata;
      end
    end
  end

  assign mem_clk_enable = clk_enable;
  assign mem_address    = r_addr;
  assign mem_writedata  = r_wdata;
  assign ack0           = r_ack0;
  assign ack1           = r_ack1;
  assign rd0_data       = r_rd0;
  assign rd1_data       = r_rd1;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_mips_data_mem_arbiter.sv
// Bench for mips_data_mem_arbiter: a round-robin and a fixed-priority instance share stimulus;
// each has its own memory and a transaction-level reference scheduler feeding a scoreboard.
module tb_mips_data_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clk_enable = 1'b0;
  logic          req0_read = 1'b0;
  logic          req0_write = 1'b0;
  logic [AW-1:0] req0_address = '0;
  logic [DW-1:0] req0_writedata = '0;
  logic          req1_read = 1'b0;
  logic          req1_write = 1'b0;
  logic [AW-1:0] req1_address = '0;
  logic [DW-1:0] req1_writedata = '0;

  logic [1:0]    ack0_w;
  logic [1:0]    ack1_w;
  logic [1:0]    mem_ce_w;
  logic [1:0]    mem_wr_w;
  logic [1:0]    mem_rd_w;
  logic [DW-1:0] rd0_w [2];
  logic [DW-1:0] rd1_w [2];
  logic [DW-1:0] mem_wd_w [2];
  logic [DW-1:0] mem_rdata_w [2];
  logic [AW-1:0] mem_addr_w [2];
  logic [1:0]    dbg_w [2];

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic        port;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdv;
    logic [31:0] gedge;
  } exp_t;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Instance 0 is round-robin, instance 1 is fixed priority.
  for (genvar d = 0; d < 2; d++) begin : g_chk
    logic [31:0] env_mem [64] = '{default: '0};
    logic [31:0] env_rdata = '0;
    logic [31:0] ref_mem [64] = '{default: '0};
    exp_t        q[$];
    logic [31:0] exp_rd [2] = '{default: '0};
    int unsigned e_cnt = 0;
    int unsigned next_free = 0;
    int unsigned mask_e = 0;
    logic        have_mask = 1'b0;
    logic        mask_p = 1'b0;
    logic        last_served = 1'b1;
    logic        prev_fresh = 1'b0;
    int          ack_cnt = 0;

    mips_data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(d)) u_dut (
      .clk            (clk),
      .reset          (reset),
      .clk_enable     (clk_enable),
      .req0_read      (req0_read),
      .req0_write     (req0_write),
      .req0_address   (req0_address),
      .req0_writedata (req0_writedata),
      .ack0           (ack0_w[d]),
      .rd0_data       (rd0_w[d]),
      .req1_read      (req1_read),
      .req1_write     (req1_write),
      .req1_address   (req1_address),
      .req1_writedata (req1_writedata),
      .ack1           (ack1_w[d]),
      .rd1_data       (rd1_w[d]),
      .mem_clk_enable (mem_ce_w[d]),
      .mem_address    (mem_addr_w[d]),
      .mem_write      (mem_wr_w[d]),
      .mem_read       (mem_rd_w[d]),
      .mem_writedata  (mem_wd_w[d]),
      .mem_readdata   (mem_rdata_w[d]),
      .o_dbg_state    (dbg_w[d])
    );

    // Single-port memory: registered read data valid the cycle after mem_read.
    always @(posedge clk) begin
      if (mem_ce_w[d]) begin
        if (mem_wr_w[d]) env_mem[mem_addr_w[d][5:0]] <= mem_wd_w[d];
        if (mem_rd_w[d]) env_rdata <= env_mem[mem_addr_w[d][5:0]];
      end
    end
    assign mem_rdata_w[d] = env_rdata;

    // Reference scheduler: counts enabled edges; the arbiter is free again three
    // edges after a grant, and the port just acked is ignored at that first free edge.
    always @(posedge clk) begin
      logic el0;
      logic el1;
      logic win;
      exp_t ent;
      prev_fresh = reset && clk_enable;
      if (!reset) begin
        q.delete();
        next_free   = 0;
        have_mask   = 1'b0;
        last_served = 1'b1;
        exp_rd[0]   = '0;
        exp_rd[1]   = '0;
      end else if (clk_enable) begin
        e_cnt++;
        if (e_cnt >= next_free) begin
          el0 = (req0_read || req0_write) && !(have_mask && mask_e == e_cnt && !mask_p);
          el1 = (req1_read || req1_write) && !(have_mask && mask_e == e_cnt && mask_p);
          if (el0 || el1) begin
            if (el0 && el1) win = (d == 1) ? 1'b0 : !last_served;
            else win = el1;
            last_served = win;
            ent.port  = win;
            ent.wr    = win ? req1_write : req0_write;
            ent.addr  = win ? req1_address : req0_address;
            ent.wd    = win ? req1_writedata : req0_writedata;
            ent.gedge = e_cnt;
            ent.rdv   = '0;
            if (ent.wr) ref_mem[ent.addr[5:0]] = ent.wd;
            else ent.rdv = ref_mem[ent.addr[5:0]];
            q.push_back(ent);
            next_free = e_cnt + 3;
            mask_e    = e_cnt + 3;
            mask_p    = win;
            have_mask = 1'b1;
          end
        end
      end
    end

    // Monitor: only looks at cycles that follow an enabled edge, so frozen cycles are not recounted.
    always @(negedge clk) begin
      exp_t f;
      if (reset && prev_fresh) begin
        if (mem_rd_w[d] || mem_wr_w[d]) begin
          check_b($sformatf("d%0d_strobe_excl", d), mem_rd_w[d] & mem_wr_w[d], 1'b0);
          if (q.size() == 0) begin
            fail_now($sformatf("d%0d_strobe_unexpected", d));
          end else begin
            f = q[0];
            check($sformatf("d%0d_strobe_addr", d), mem_addr_w[d], f.addr);
            check_b($sformatf("d%0d_strobe_wr", d), mem_wr_w[d], f.wr);
            if (f.wr) check($sformatf("d%0d_strobe_wdata", d), mem_wd_w[d], f.wd);
            check($sformatf("d%0d_strobe_edge", d), e_cnt, f.gedge);
          end
        end
        if (ack0_w[d] || ack1_w[d]) begin
          check_b($sformatf("d%0d_ack_onehot", d), ack0_w[d] & ack1_w[d], 1'b0);
          if (q.size() == 0) begin
            fail_now($sformatf("d%0d_ack_unexpected", d));
          end else begin
            f = q.pop_front();
            ack_cnt++;
            check_b($sformatf("d%0d_ack_port", d), ack1_w[d], f.port);
            check($sformatf("d%0d_ack_edge", d), e_cnt, f.gedge + 32'd2);
            if (!f.wr) exp_rd[f.port] = f.rdv;
            check($sformatf("d%0d_rd0", d), rd0_w[d], exp_rd[0]);
            check($sformatf("d%0d_rd1", d), rd1_w[d], exp_rd[1]);
          end
        end
      end
    end
  end

  task automatic wait_ack(input logic port, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #2;
      cyc++;
    end while (!(port ? ack1_w[0] : ack0_w[0]) && cyc < 40);
    if (!(port ? ack1_w[0] : ack0_w[0])) fail_now("ack_timeout");
  endtask

  initial begin
    int   cyc;
    int   order[$];
    logic got0;
    logic got1;

    clk_enable = 1'b1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      check_b("rst_ack0", ack0_w[d], 1'b0);
      check_b("rst_ack1", ack1_w[d], 1'b0);
      check("rst_rd0", rd0_w[d], 32'd0);
      check("rst_rd1", rd1_w[d], 32'd0);
      check_b("rst_mem_write", mem_wr_w[d], 1'b0);
      check_b("rst_mem_read", mem_rd_w[d], 1'b0);
      check("rst_mem_addr", mem_addr_w[d], 32'd0);
      check("rst_mem_wdata", mem_wd_w[d], 32'd0);
      check("rst_state", {30'd0, dbg_w[d]}, 32'd0);
    end
    reset = 1'b1;
    @(posedge clk); #2;

    // Port 0 write, then port 1 reads it back.
    req0_write = 1'b1; req0_address = 32'h10; req0_writedata = 32'h0005_0000;
    wait_ack(1'b0, cyc);
    check("w0_latency", cyc, 32'd3);
    check_b("w0_ack1_quiet", ack1_w[0], 1'b0);
    req0_write = 1'b0;
    @(posedge clk); #2;
    req1_read = 1'b1; req1_address = 32'h10;
    wait_ack(1'b1, cyc);
    check("r1_latency", cyc, 32'd3);
    check("r1_data", rd1_w[0], 32'h0005_0000);
    check("r1_rd0_unchanged", rd0_w[0], 32'd0);
    req1_read = 1'b0;
    @(posedge clk); #2;

    // Read and write together decode as a write.
    req0_read = 1'b1; req0_write = 1'b1; req0_address = 32'h20; req0_writedata = 32'hDEAD_BEEF;
    wait_ack(1'b0, cyc);
    check("rw_rd0_untouched", rd0_w[0], 32'd0);
    req0_read = 1'b0; req0_write = 1'b0;
    @(posedge clk); #2;
    req1_read = 1'b1; req1_address = 32'h20;
    wait_ack(1'b1, cyc);
    check("rw_readback", rd1_w[0], 32'hDEAD_BEEF);
    req1_read = 1'b0;
    @(posedge clk); #2;

    // Simultaneous reads, four rounds.
    for (int r = 0; r < 4; r++) begin
      req0_read = 1'b1; req0_address = 32'(r);
      req1_read = 1'b1; req1_address = 32'(r + 8);
      got0 = 1'b0; got1 = 1'b0; cyc = 0;
      while (!(got0 && got1) && cyc < 40) begin
        @(posedge clk); #2;
        cyc++;
        if (ack0_w[0]) begin order.push_back(0); got0 = 1'b1; req0_read = 1'b0; end
        if (ack1_w[0]) begin order.push_back(1); got1 = 1'b1; req1_read = 1'b0; end
      end
      if (!(got0 && got1)) fail_now("rr_round_timeout");
      @(posedge clk); #2;
    end
    check("rr_order_len", 32'(order.size()), 32'd8);
    for (int i = 0; i < order.size() && i < 8; i++) begin
      check($sformatf("rr_order_%0d", i), 32'(order[i]), 32'(i % 2));
    end

    // Freeze while in ISSUE.
    req0_read = 1'b1; req0_address = 32'h10;
    @(posedge clk); #2;
    check("frz_in_issue", {30'd0, dbg_w[0]}, 32'd1);
    clk_enable = 1'b0;
    repeat (5) begin @(posedge clk); #2; end
    check("frz_still_issue", {30'd0, dbg_w[0]}, 32'd1);
    check_b("frz_mem_ce", mem_ce_w[0], 1'b0);
    check_b("frz_strobe_held", mem_rd_w[0], 1'b1);
    clk_enable = 1'b1;
    cyc = 0;
    while (!ack0_w[0] && cyc < 10) begin @(posedge clk); #2; cyc++; end
    check("frz_ack_latency", cyc, 32'd2);
    check("frz_rd0", rd0_w[0], 32'h0005_0000);
    req0_read = 1'b0;
    clk_enable = 1'b0;
    @(posedge clk); #2;
    check_b("frz_ack_holds", ack0_w[0], 1'b1);
    clk_enable = 1'b1;
    @(posedge clk); #2;
    check_b("frz_ack_clears", ack0_w[0], 1'b0);

    // Asynchronous reset during RESP.
    req1_write = 1'b1; req1_address = 32'h30; req1_writedata = 32'h1234_5678;
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("mid_resp_state", {30'd0, dbg_w[0]}, 32'd2);
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_b("arst_ack0", ack0_w[d], 1'b0);
      check_b("arst_ack1", ack1_w[d], 1'b0);
      check("arst_state", {30'd0, dbg_w[d]}, 32'd0);
    end
    req1_write = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;

    // Random traffic with occasional clock-enable gaps.
    for (int i = 0; i < 900; i++) begin
      clk_enable     = ($urandom_range(0, 7) != 0);
      req0_read      = ($urandom_range(0, 2) == 0);
      req0_write     = ($urandom_range(0, 3) == 0);
      req0_address   = $urandom_range(0, 63);
      req0_writedata = $urandom;
      req1_read      = ($urandom_range(0, 2) == 0);
      req1_write     = ($urandom_range(0, 3) == 0);
      req1_address   = $urandom_range(0, 63);
      req1_writedata = $urandom;
      @(posedge clk); #2;
    end
    req0_read = 1'b0; req0_write = 1'b0; req1_read = 1'b0; req1_write = 1'b0;
    clk_enable = 1'b1;
    repeat (12) begin @(posedge clk); #2; end

    check("d0_queue_empty", 32'(g_chk[0].q.size()), 32'd0);
    check("d1_queue_empty", 32'(g_chk[1].q.size()), 32'd0);
    check_b("d0_acks_seen", g_chk[0].ack_cnt > 50, 1'b1);
    check_b("d1_acks_seen", g_chk[1].ack_cnt > 50, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule

// File: doc/mips_data_mem_arbiter.md
Name: mips_data_mem_arbiter

Overview:
- Shares the single-port mips_cpu_data_memory between two requesters: port 0 is the CPU data port, port 1 is a loader/DMA port used to preload or inspect memory.
- Round-robin arbitration with a request/ack handshake per port.
- Drives the memory's clk_enable, address, write, read and writedata signals.
- Sits between mips_cpu_harvard and mips_cpu_data_memory in the top-level and in testbenches.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- FIXED_PRIO, 0, 1 = port 0 always wins; 0 = round-robin

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low; asserted when 0
- clk_enable  input  1  global enable; when 0, all state and registers hold
- req0_read  input  1  port 0 read request
- req0_write  input  1  port 0 write request
- req0_address  input  ADDR_W  port 0 address
- req0_writedata  input  DATA_W  port 0 write data
- ack0  output  1  port 0 completion pulse
- rd0_data  output  DATA_W  port 0 read data
- req1_read, req1_write, req1_address, req1_writedata, ack1, rd1_data: same as port 0, for port 1
- mem_clk_enable  output  1  to memory clk_enable
- mem_address  output  ADDR_W  to memory
- mem_write  output  1  to memory
- mem_read  output  1  to memory
- mem_writedata  output  DATA_W  to memory
- mem_readdata  input  DATA_W  from memory; valid in the cycle after mem_read

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, rr_last=1 (port 0 wins first tie).
  - ack0=ack1=0, rd0_data=rd1_data=0.
  - mem_write=mem_read=0, mem_address=0, mem_writedata=0.
- FSM states: IDLE, ISSUE, RESP. Transitions occur only on rising edges with clk_enable=1.
- Eligibility: port N is eligible if (reqN_read | reqN_write) and ackN=0. A port whose ack is high this cycle is masked, so a held request is not re-served.
- IDLE: if no port is eligible, stay in IDLE. Otherwise pick the winner and latch the winner id, op, address and writedata; go to ISSUE.
- Winner selection:
  - Only one port eligible: that port wins.
  - Both eligible, FIXED_PRIO=1: port 0 wins.
  - Both eligible, FIXED_PRIO=0: the port other than rr_last wins; rr_last is updated to the winner.
- Op decode: read and write both asserted = write; no read is performed.
- ISSUE (1 cycle):
  - mem_address and mem_writedata come from the latched values.
  - Exactly one of mem_write or mem_read is high.
  - Next state is RESP.
- RESP (1 cycle):
  - mem_write=mem_read=0.
  - Read op: at the end of RESP, load rd<winner>_data from mem_readdata.
  - At the end of RESP, set ack<winner>=1 for exactly the next cycle; go to IDLE.
- Latency: request sampled at edge E0; ISSUE between E0 and E1; RESP between E1 and E2; ackN and rdN_data valid between E2 and E3.
  - Best case is 3 cycles from request to ack.
  - Back-to-back throughput is one access per 3 cycles.
- Holding and outputs:
  - rdN_data holds until the next read completion on that port.
  - Writes do not change rdN_data.
- Requester rules:
  - Hold request, address and data stable until ack.
  - Drop or change the request in the cycle after ack.
  - Changing inputs while pending is allowed; the values are latched at grant.
- mem_clk_enable equals clk_enable combinationally.
- clk_enable=0 mid-operation: state, latches and ack freeze. Ack stays high until clk_enable returns and one enabled edge passes.
- Async reset mid-ISSUE: the access is aborted and no ack is generated. The memory write may or may not have landed; this is documented, not checked.
- Starvation: round-robin guarantees each eligible port is served within 2 grants. FIXED_PRIO=1 may starve port 1 by design.

Test Plan:
- Reset at 0, release, port 0 writes 0x50000 to address 0x10 → mem_write high for 1 cycle with mem_address=0x10; ack0 pulses 3 cycles after request; ack1 stays 0.
- Port 1 reads 0x10 after that write → mem_read high for 1 cycle; rd1_data=0x00050000 while ack1=1; rd0_data unchanged.
- Both ports request reads in the same cycle with FIXED_PRIO=0, repeated 4 times → grants alternate 0,1,0,1; each ack is a single-cycle pulse; no port is served twice consecutively while the other waits.
- Same stimulus with FIXED_PRIO=1 → port 0 is always granted while its request recurs; port 1 is served only when port 0 is idle.
- read=write=1 on port 0, address 0x20, data 0xDEADBEEF → write performed (mem_read never high); a subsequent read returns 0xDEADBEEF.
- clk_enable=0 for 5 cycles during ISSUE, then 1 → FSM resumes in ISSUE; memory strobes do not repeat extra times; ack arrives 2 enabled edges later. Async reset asserted mid-RESP → ack0=ack1=0 and state=IDLE immediately.
